// File: rtl/half_adder_unit.sv
// Bit-parallel half adder: combinational sum/carry plus a one-cycle registered copy with valid tracking.
// Optional saturating carry-event counter, enabled by defining HALF_ADDER_COUNT_EN.
module half_adder_unit #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     sum,
    output logic [WIDTH-1:0]     carry,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     sum_q,
    output logic [WIDTH-1:0]     carry_q,
`ifdef HALF_ADDER_COUNT_EN
    output logic                 out_valid,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] carry_cnt
`else
    output logic                 out_valid
`endif
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] carry_s;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] carry_r;
    logic             out_valid_r;

    // Per-lane half-adder equations; independent of clock, reset and valid.
    always_comb begin
        sum_s   = a ^ b;
        carry_s = a & b;
    end

    assign sum       = sum_s;
    assign carry     = carry_s;
    assign sum_q     = sum_r;
    assign carry_q   = carry_r;
    assign out_valid = out_valid_r;

    // Registered result: loads on accepted input, otherwise holds; valid follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r       <= {WIDTH{1'b0}};
            carry_r     <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                sum_r   <= sum_s;
                carry_r <= carry_s;
            end else begin
                sum_r   <= sum_r;
                carry_r <= carry_r;
            end
        end
    end

`ifdef HALF_ADDER_COUNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 carry_event_s;

    // One event per accepted beat with any carry lane set, regardless of how many lanes carry.
    always_comb begin
        carry_event_s = in_valid & (|carry_s);
    end

    // Saturating event counter; clear wins over a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (carry_event_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign carry_cnt = cnt_r;
`endif

    half_adder_unit_chk #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_chk (
        .sum   (sum_s),
        .carry (carry_s)
    );

endmodule

// Invariant checks for half_adder_unit: sum and carry never both set in a lane.
module half_adder_unit_chk #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input logic [WIDTH-1:0] sum,
    input logic [WIDTH-1:0] carry
);

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("half_adder_unit: CNT_WIDTH must be at least 1");
    end

    // A half adder can never produce sum=1 and carry=1 in the same lane.
    always_comb begin
        assert ((sum & carry) == {WIDTH{1'b0}})
        else $error("half_adder_unit: sum and carry both set, sum=%0h carry=%0h", sum, carry);
    end

endmodule

// File: tb/tb_half_adder_unit.sv
// Directed self-checking bench for half_adder_unit (WIDTH=1 and WIDTH=4 instances).
module tb_half_adder_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1, iv1, sum1, carry1, sq1, cq1, ov1;
    logic [3:0] a4, b4, sum4, carry4, sq4, cq4;
    logic       iv4, ov4;
`ifdef HALF_ADDER_COUNT_EN
    logic        clr1, clr4;
    logic [15:0] cnt1;
    logic [1:0]  cnt4;
`endif
    int checks = 0;
    int errors = 0;
    logic [3:0] exp_s_tab;
    logic [3:0] exp_c_tab;
    logic [1:0] sat_tab [5];

    always #5 clk = ~clk;

    half_adder_unit #(.WIDTH(1), .CNT_WIDTH(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sum(sum1), .carry(carry1),
        .in_valid(iv1), .sum_q(sq1), .carry_q(cq1),
`ifdef HALF_ADDER_COUNT_EN
        .out_valid(ov1), .cnt_clr(clr1), .carry_cnt(cnt1)
`else
        .out_valid(ov1)
`endif
    );

    half_adder_unit #(.WIDTH(4), .CNT_WIDTH(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .sum(sum4), .carry(carry4),
        .in_valid(iv4), .sum_q(sq4), .carry_q(cq4),
`ifdef HALF_ADDER_COUNT_EN
        .out_valid(ov4), .cnt_clr(clr4), .carry_cnt(cnt4)
`else
        .out_valid(ov4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        a4 = 4'b0000; b4 = 4'b0000; iv4 = 1'b1;
`ifdef HALF_ADDER_COUNT_EN
        clr1 = 1'b0; clr4 = 1'b0;
`endif
        #2;
        chk("rst_sum_q", 32'(sq1), 32'd0);
        chk("rst_out_valid", 32'(ov1), 32'd0);
        chk("rst_comb_carry", 32'(carry1), 32'd1);
        step();
        chk("rst_ignore_valid", 32'(ov1), 32'd0);
        chk("rst_ignore_carry_q", 32'(cq1), 32'd0);
        @(negedge clk);
        iv1 = 1'b0; iv4 = 1'b0;
        rst_n = 1'b1;

        // Truth table, one vector per 10 time units
        exp_s_tab = 4'b0110;
        exp_c_tab = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a1 = i[1]; b1 = i[0];
            #1;
            chk($sformatf("tt_sum_%0d", i), 32'(sum1), 32'(exp_s_tab[i]));
            chk($sformatf("tt_carry_%0d", i), 32'(carry1), 32'(exp_c_tab[i]));
        end

        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        step();
        chk("reg11_sum_q", 32'(sq1), 32'd0);
        chk("reg11_carry_q", 32'(cq1), 32'd1);
        chk("reg11_out_valid", 32'(ov1), 32'd1);
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; iv1 = 1'b0;
        step();
        chk("hold_sum_q", 32'(sq1), 32'd0);
        chk("hold_carry_q", 32'(cq1), 32'd1);
        chk("hold_out_valid", 32'(ov1), 32'd0);

        // Back-to-back accepted inputs
        @(negedge clk);
        iv1 = 1'b1;
        step();
        chk("b2b1_sum_q", 32'(sq1), 32'd1);
        chk("b2b1_carry_q", 32'(cq1), 32'd0);
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1;
        step();
        chk("b2b2_sum_q", 32'(sq1), 32'd0);
        chk("b2b2_carry_q", 32'(cq1), 32'd1);
        chk("b2b2_out_valid", 32'(ov1), 32'd1);

        @(negedge clk);
        a4 = 4'b1100; b4 = 4'b1010; iv4 = 1'b1;
        #1;
        chk("w4_sum", 32'(sum4), 32'h6);
        chk("w4_carry", 32'(carry4), 32'h8);
        step();
        chk("w4_sum_q", 32'(sq4), 32'h6);
        chk("w4_carry_q", 32'(cq4), 32'h8);
        chk("w4_out_valid", 32'(ov4), 32'd1);

        // Asynchronous reset pulse between edges while out_valid is high
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_carry_q1", 32'(cq1), 32'd0);
        chk("arst_out_valid1", 32'(ov1), 32'd0);
        chk("arst_sum_q4", 32'(sq4), 32'h0);
        chk("arst_carry_q4", 32'(cq4), 32'h0);
        chk("arst_out_valid4", 32'(ov4), 32'd0);
`ifdef HALF_ADDER_COUNT_EN
        chk("arst_cnt1", 32'(cnt1), 32'd0);
`endif
        a1 = 1'b0;
        #1;
        chk("arst_comb_sum", 32'(sum1), 32'd1);
        chk("arst_comb_carry", 32'(carry1), 32'd0);
        a1 = 1'b1; b1 = 1'b0; iv4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_sum_q", 32'(sq1), 32'd1);
        chk("post_rst_out_valid", 32'(ov1), 32'd1);

`ifdef HALF_ADDER_COUNT_EN
        @(negedge clk);
        a4 = 4'b0001; b4 = 4'b0010; iv4 = 1'b1;
        step();
        chk("cnt_nocarry", 32'(cnt4), 32'd0);
        sat_tab[0] = 2'd1; sat_tab[1] = 2'd2; sat_tab[2] = 2'd3;
        sat_tab[3] = 2'd3; sat_tab[4] = 2'd3;
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("cnt_sat_%0d", i), 32'(cnt4), 32'(sat_tab[i]));
        end
        @(negedge clk);
        clr4 = 1'b1;
        step();
        chk("cnt_clr_prio", 32'(cnt4), 32'd0);
        @(negedge clk);
        clr4 = 1'b0; iv4 = 1'b0;
        step();
        chk("cnt_no_valid", 32'(cnt4), 32'd0);
        @(negedge clk);
        iv4 = 1'b1;
        step();
        chk("cnt_after_clr", 32'(cnt4), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
